// File: rtl/stream_right_shifter.sv
// stream_right_shifter: shifts a block-serial little-endian big integer right by a per-number bit count.
// Define STREAM_RIGHT_SHIFTER_ZERO_PAD_EN to pad each number back to NUM_BLOCKS outputs with zero blocks.
module stream_right_shifter #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 256,
  parameter int MAX_SHIFT     = 4096,
  parameter int SW            = $clog2(MAX_SHIFT + 1)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [SW-1:0]            shift_amt_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] block_in,
  output logic                     ready_out,
  output logic                     valid_out,
  output logic [REGISTER_SIZE-1:0] data_block_out,
  output logic                     last_out,
  input  logic                     ready_in
);
  localparam int CW = $clog2(NUM_BLOCKS) + 1;
  localparam int BW = $clog2(REGISTER_SIZE);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BLOCKS - 1);
  localparam logic [CW-1:0] END_IDX  = CW'(NUM_BLOCKS);
  typedef enum logic [2:0] {
    IDLE, SKIP, PRIME, STREAM, TAIL
`ifdef STREAM_RIGHT_SHIFTER_ZERO_PAD_EN
    , PAD
`endif
  } state_t;
  state_t                   state;
  logic [CW-1:0]            in_cnt;
  logic [CW-1:0]            ws;
  logic [BW-1:0]            b;
  logic [REGISTER_SIZE-1:0] hold;
  logic [SW-1:0]            s_clamp;
  logic [CW-1:0]            ws_new;
  logic [BW-1:0]            b_new;
  logic [2*REGISTER_SIZE-1:0] cat;
  logic [REGISTER_SIZE-1:0] tail;
  logic                     slot_free;
  logic                     acc;
`ifdef STREAM_RIGHT_SHIFTER_ZERO_PAD_EN
  logic [CW-1:0]            out_cnt;
`endif
  assign s_clamp   = shift_amt_in > SW'(MAX_SHIFT) ? SW'(MAX_SHIFT) : shift_amt_in;
  assign ws_new    = CW'(32'(s_clamp) / REGISTER_SIZE);
  assign b_new     = BW'(32'(s_clamp) % REGISTER_SIZE);
  assign cat       = {block_in, hold} >> b;
  assign tail      = hold >> b;
  assign slot_free = !valid_out || ready_in;
  // PRIME with every input block already consumed only waits for TAIL; refuse input there.
  assign ready_out = (state == IDLE || state == SKIP) ? 1'b1 :
                     ((state == PRIME && in_cnt != END_IDX) || state == STREAM) ? slot_free : 1'b0;
  assign acc       = valid_in && ready_out;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state          <= IDLE;
      in_cnt         <= '0;
      ws             <= '0;
      b              <= '0;
      hold           <= '0;
      valid_out      <= 1'b0;
      data_block_out <= '0;
      last_out       <= 1'b0;
`ifdef STREAM_RIGHT_SHIFTER_ZERO_PAD_EN
      out_cnt        <= '0;
`endif
    end else begin
      if (ready_in) valid_out <= 1'b0;
      case (state)
        IDLE: if (valid_in) begin
          ws     <= ws_new;
          b      <= b_new;
          in_cnt <= CW'(1);
          hold   <= block_in;
          state  <= ws_new == '0 ? PRIME : SKIP;
        end
        SKIP: if (valid_in) begin
          in_cnt <= in_cnt + CW'(1);
          if (in_cnt == ws) begin
            hold  <= block_in;
            state <= PRIME;
          end
        end
        PRIME, STREAM:
          if (state == PRIME && in_cnt == END_IDX) state <= TAIL;
          else if (acc) begin
            data_block_out <= cat[REGISTER_SIZE-1:0];
            valid_out      <= 1'b1;
            last_out       <= 1'b0;
            hold           <= block_in;
            in_cnt         <= in_cnt + CW'(1);
            state          <= in_cnt == LAST_IDX ? TAIL : STREAM;
          end
        TAIL: if (slot_free) begin
          data_block_out <= tail;
          valid_out      <= 1'b1;
`ifdef STREAM_RIGHT_SHIFTER_ZERO_PAD_EN
          last_out       <= ws == '0;
          out_cnt        <= '0;
          state          <= ws == '0 ? IDLE : PAD;
`else
          last_out       <= 1'b1;
          state          <= IDLE;
`endif
        end
`ifdef STREAM_RIGHT_SHIFTER_ZERO_PAD_EN
        PAD: if (slot_free) begin
          data_block_out <= '0;
          valid_out      <= 1'b1;
          last_out       <= out_cnt == ws - CW'(1);
          out_cnt        <= out_cnt + CW'(1);
          state          <= out_cnt == ws - CW'(1) ? IDLE : PAD;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_stream_right_shifter.sv
// tb_stream_right_shifter: directed stimulus with a big-integer reference model and scoreboard.
module tb_stream_right_shifter;
  localparam int RS = 32;
  localparam int NB = 4;
  localparam int MS = 96;
  localparam int SW = $clog2(MS + 1);
  typedef logic [RS-1:0] blk_t [NB];
  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic [SW-1:0] shift_amt_in = '0;
  logic          valid_in = 1'b0;
  logic [RS-1:0] block_in = '0;
  logic          ready_out;
  logic          valid_out;
  logic [RS-1:0] data_block_out;
  logic          last_out;
  logic          ready_in = 1'b1;
  int            checks = 0;
  int            errors = 0;
  logic [RS:0]   exp_q[$];
  blk_t a = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  blk_t c = '{32'h87654321, 32'hFEDCBA98, 32'h00000001, 32'h00000000};
  blk_t d = '{32'h00000001, 32'h00000002, 32'h00000003, 32'hA0000000};
  always #5 clk_in = ~clk_in;
  stream_right_shifter #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .MAX_SHIFT(MS)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .shift_amt_in(shift_amt_in), .valid_in(valid_in),
    .block_in(block_in), .ready_out(ready_out), .valid_out(valid_out),
    .data_block_out(data_block_out), .last_out(last_out), .ready_in(ready_in));
  function automatic logic [RS-1:0] ref_block(int s, blk_t in, int k);
    logic [NB*RS-1:0] v;
    for (int i = 0; i < NB; i++) v[i*RS +: RS] = in[i];
    v = v >> (s > MS ? MS : s);
    return v[k*RS +: RS];
  endfunction
  function automatic int n_out(int s);
`ifdef STREAM_RIGHT_SHIFTER_ZERO_PAD_EN
    return s < 0 ? 0 : NB;
`else
    return NB - (s > MS ? MS : s) / RS;
`endif
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic monitor();
    logic       prev_stall = 1'b0;
    logic [RS+1:0] prev = '0;
    logic [RS:0]   e;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) prev_stall = 1'b0;
      else begin
        if (prev_stall) check("stall_hold", {valid_out, last_out, data_block_out}, prev);
        if (valid_out && ready_in) begin
          if (exp_q.size() == 0) check("extra_output", {last_out, data_block_out}, 64'hDEAD);
          else begin
            e = exp_q.pop_front();
            check("output", {last_out, data_block_out}, e);
          end
        end
        prev_stall = valid_out && !ready_in;
        prev = {valid_out, last_out, data_block_out};
      end
    end
  endtask
  task automatic send_block(logic [RS-1:0] v, logic [SW-1:0] s);
    bit acc = 1'b0;
    int n = 0;
    valid_in = 1'b1;
    block_in = v;
    shift_amt_in = s;
    while (!acc && n < 100) begin
      @(negedge clk_in);
      acc = ready_out;
      @(posedge clk_in);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    valid_in = 1'b0;
  endtask
  task automatic send_number(int s, blk_t in, int nblk = NB);
    int n = n_out(s);
    for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, ref_block(s, in, k)});
    for (int i = 0; i < nblk; i++) send_block(in[i], SW'(s));
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_in);
      n++;
    end
    repeat (3) @(posedge clk_in);
    #1;
    check("drain_left", 64'(exp_q.size()), 0);
  endtask
  initial begin
    fork monitor(); join_none
    #12;
    check("rst_valid", valid_out, 0);
    check("rst_data", data_block_out, 0);
    check("rst_last", last_out, 0);
    rst_n_in = 1'b1;
    #1;
    check("rst_ready", ready_out, 1);
    check("pin_s0", ref_block(0, a, 3), 32'h44444444);
    check("pin_s32", ref_block(32, a, 0), 32'h22222222);
    check("pin_s36_k0", ref_block(36, c, 0), 32'h1FEDCBA9);
    check("pin_s36_k1", ref_block(36, c, 1), 32'h00000000);
    check("pin_clamp", ref_block(127, d, 0), 32'hA0000000);
    @(posedge clk_in);
    #1;
    send_number(0, a);
    drain();
    send_number(32, a);
    drain();
    send_number(36, c);
    drain();
    // 200 does not fit the 7-bit port; 127 exercises the same clamp to MAX_SHIFT.
    send_number(127, d);
    drain();
    fork
      send_number(4, a);
      begin
        int n = 0;
        while (!valid_out && n < 50) begin
          @(posedge clk_in);
          #1;
          n++;
        end
        check("stall_first_valid", valid_out, 1);
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        repeat (5) begin
          @(negedge clk_in);
          check("stall_ready", ready_out, 0);
          @(posedge clk_in);
          #1;
        end
        ready_in = 1'b1;
      end
    join
    drain();
    send_number(8, a, 2);
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_block_out, 0);
    check("mid_rst_last", last_out, 0);
    exp_q.delete();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check("mid_rst_ready", ready_out, 1);
    @(posedge clk_in);
    #1;
    send_number(0, a);
    send_number(40, c);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
